// File: rtl/nn_ctrl_pkg.sv
// Shared types and defaults for the output-neuron control slice.
package nn_ctrl_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_NUM_WEIGHTS = 3;
  localparam int LAST_ADDR       = DEF_NUM_WEIGHTS - 1;

  typedef enum logic [1:0] {
    UNLOADED = 2'd0,
    LOAD     = 2'd1,
    READY    = 2'd2,
    OUT      = 2'd3
  } nn_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero after MAX; clear has priority over increment.
module wrap_counter #(
  parameter int           W   = 2,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= (r_cnt == MAX) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/output_neuron_sequencer.sv
// Loads the output neuron's weight file from the host stream and fires one inference
// per accepted activation set, holding the score valid until downstream takes it.
//
//  state    | meaning
//  UNLOADED | no weights resident since reset; waiting for word 0
//  LOAD     | mid-burst; weight set incomplete, neuron may not fire
//  READY    | full weight set resident; accepts activations or a reload
//  OUT      | score valid, waiting for score_ready
module output_neuron_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_WEIGHTS = DEF_NUM_WEIGHTS,
  parameter int ADDR_W      = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [DATA_W-1:0] i_cfg_data,
  input  logic              i_act_valid,
  output logic              o_act_ready,
  output logic              o_nrn_wen,
  output logic [ADDR_W-1:0] o_nrn_weight_addr,
  output logic [DATA_W-1:0] o_nrn_weight_in,
  output logic              o_nrn_en,
  output logic              o_score_valid,
  input  logic              i_score_ready,
  output logic              o_weights_loaded,
  output logic [CNT_W-1:0]  o_infer_count
);

  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(NUM_WEIGHTS - 1);

  nn_state_t         r_state;
  nn_state_t         w_next;
  logic              r_loaded;
  logic              w_loaded_nxt;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_cfg_ready;
  logic              w_act_ready;
  logic              w_wr;
  logic              w_fire;
  logic              w_take;
  logic              w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= UNLOADED;
      r_loaded <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_loaded <= w_loaded_nxt;
    end
  end

  assign w_last = (w_waddr == W_LAST);

  // Activation beats a simultaneous reload so the resident set is used before it is replaced.
  always_comb begin
    w_next       = r_state;
    w_loaded_nxt = r_loaded;
    w_cfg_ready  = 1'b0;
    w_act_ready  = 1'b0;
    w_fire       = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      UNLOADED, LOAD: w_cfg_ready = 1'b1;
      READY: begin
        w_act_ready = r_loaded;
        w_fire      = r_loaded && i_act_valid;
        w_cfg_ready = !w_fire;
      end
      OUT:     w_take = i_score_ready;
      default: ;
    endcase
    w_wr = i_cfg_valid && w_cfg_ready;
    if (w_fire) begin
      w_next = OUT;
    end else if (w_wr) begin
      w_loaded_nxt = w_last;
      w_next       = w_last ? READY : LOAD;
    end else if (w_take) begin
      w_next = READY;
    end
  end

  wrap_counter #(
    .W   (ADDR_W),
    .MAX (W_LAST)
  ) u_waddr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr),
    .i_clr (1'b0),
    .o_cnt (w_waddr)
  );

  wrap_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_infer_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_take),
    .i_clr (1'b0),
    .o_cnt (o_infer_count)
  );

  assign o_cfg_ready       = w_cfg_ready;
  assign o_act_ready       = w_act_ready;
  assign o_nrn_wen         = w_wr;
  assign o_nrn_weight_addr = w_wr ? w_waddr : '0;
  assign o_nrn_weight_in   = w_wr ? i_cfg_data : '0;
  assign o_nrn_en          = w_fire;
  assign o_score_valid     = (r_state == OUT);
  assign o_weights_loaded  = r_loaded;

endmodule

// File: tb/tb_output_neuron_sequencer.sv
// Bench for output_neuron_sequencer: two instances (16-bit and 2-bit inference counter) share
// stimulus; a rule-level model and a stand-in neuron check every cycle.
module tb_output_neuron_sequencer;
  localparam int DW = 16;
  localparam int NW = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          act_valid = 1'b0;
  logic          score_ready = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic [DW-1:0] relu [NW];

  logic          a_cfg_ready, a_act_ready, a_wen, a_en, a_sv, a_wl;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_win;
  logic [15:0]   a_cnt;
  logic          b_cfg_ready, b_act_ready, b_wen, b_en, b_sv, b_wl;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_win;
  logic [1:0]    b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  output_neuron_sequencer #(.DATA_W(DW), .NUM_WEIGHTS(NW), .ADDR_W(AW), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(a_cfg_ready), .i_cfg_data(cfg_data),
    .i_act_valid(act_valid), .o_act_ready(a_act_ready),
    .o_nrn_wen(a_wen), .o_nrn_weight_addr(a_addr), .o_nrn_weight_in(a_win),
    .o_nrn_en(a_en), .o_score_valid(a_sv), .i_score_ready(score_ready),
    .o_weights_loaded(a_wl), .o_infer_count(a_cnt)
  );

  output_neuron_sequencer #(.DATA_W(DW), .NUM_WEIGHTS(NW), .ADDR_W(AW), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(b_cfg_ready), .i_cfg_data(cfg_data),
    .i_act_valid(act_valid), .o_act_ready(b_act_ready),
    .o_nrn_wen(b_wen), .o_nrn_weight_addr(b_addr), .o_nrn_weight_in(b_win),
    .o_nrn_en(b_en), .o_score_valid(b_sv), .i_score_ready(score_ready),
    .o_weights_loaded(b_wl), .o_infer_count(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: handshake never happened at %0t", nm, $time);
  endtask

  // Stand-in neuron: weight file written on wen, score registered on en.
  logic [DW-1:0] nw [NW];
  logic [DW-1:0] n_score;
  logic [DW-1:0] n_sum;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) nw[i] <= '0;
      n_score <= '0;
    end else begin
      if (a_wen) nw[a_addr] <= a_win;
      if (a_en) begin
        n_sum = '0;
        for (int i = 0; i < NW; i++) n_sum = n_sum + nw[i] * relu[i];
        n_score <= n_sum;
      end
    end
  end

  // Rule-level model: what is resident, which word comes next, whether a score is pending.
  bit m_loaded = 0;
  int m_next   = 0;
  bit m_out    = 0;
  int m_cnt    = 0;
  int m_w [NW] = '{0, 0, 0};
  int exp_q [$];
  int wq [$];
  int n_wen = 0, n_en = 0, n_fired = 0, n_taken = 0;
  bit e_cr, e_ar, e_fire, e_wen, e_sv;
  int m_sum;

  always @(negedge clk) begin
    if (m_out) begin
      e_sv = 1; e_ar = 0; e_fire = 0; e_cr = 0; e_wen = 0;
    end else begin
      e_sv   = 0;
      e_ar   = m_loaded;
      e_fire = e_ar && act_valid;
      e_cr   = !e_fire;
      e_wen  = cfg_valid && e_cr;
    end
    check("cfg_ready", {a_cfg_ready, b_cfg_ready}, {e_cr, e_cr});
    check("act_ready", {a_act_ready, b_act_ready}, {e_ar, e_ar});
    check("nrn_en", {a_en, b_en}, {e_fire, e_fire});
    check("nrn_wen", {a_wen, b_wen}, {e_wen, e_wen});
    check("score_valid", {a_sv, b_sv}, {e_sv, e_sv});
    check("weights_loaded", {a_wl, b_wl}, {m_loaded, m_loaded});
    check("waddr_a", 32'(a_addr), e_wen ? 32'(m_next) : 32'd0);
    check("waddr_b", 32'(b_addr), e_wen ? 32'(m_next) : 32'd0);
    check("wdata_a", 32'(a_win), e_wen ? 32'(cfg_data) : 32'd0);
    check("wdata_b", 32'(b_win), e_wen ? 32'(cfg_data) : 32'd0);
    check("count16", 32'(a_cnt), m_cnt % 65536);
    check("count2", 32'(b_cnt), m_cnt % 4);
    if (a_wen) begin n_wen++; wq.push_back(int'(a_addr)); end
    if (a_en) n_en++;
    if (a_sv && score_ready) begin
      n_taken++;
      if (exp_q.size() == 0) timeout("score_unexpected");
      else check("score", 32'(n_score), 32'(exp_q.pop_front()));
    end
    if (rst) begin
      m_loaded = 0; m_next = 0; m_out = 0; m_cnt = 0;
      for (int i = 0; i < NW; i++) m_w[i] = 0;
      exp_q.delete();
    end else if (m_out) begin
      if (score_ready) begin m_out = 0; m_cnt++; end
    end else if (e_fire) begin
      m_sum = 0;
      for (int i = 0; i < NW; i++) m_sum += m_w[i] * int'(relu[i]);
      exp_q.push_back(m_sum & 16'hFFFF);
      m_out = 1;
      n_fired++;
    end else if (e_wen) begin
      m_w[m_next] = int'(cfg_data);
      if (m_next == NW - 1) begin m_loaded = 1; m_next = 0; end
      else begin m_loaded = 0; m_next++; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit hs = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge clk);
      hs = a_cfg_ready;
      tick();
    end
    if (!hs) timeout("cfg_handshake");
  endtask

  task automatic fire(input int r0, input int r1, input int r2);
    bit hs = 0;
    relu[0] = DW'(r0); relu[1] = DW'(r1); relu[2] = DW'(r2);
    act_valid = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge clk);
      hs = a_act_ready;
      tick();
    end
    act_valid = 1'b0;
    if (!hs) timeout("act_handshake");
  endtask

  task automatic take();
    bit hs = 0;
    score_ready = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge clk);
      hs = a_sv;
      tick();
    end
    score_ready = 1'b0;
    if (!hs) timeout("score_handshake");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  int en_before, wen_before;

  initial begin
    relu[0] = '0; relu[1] = '0; relu[2] = '0;
    // T1 reset
    repeat (3) tick();
    rst = 1'b0;
    check("t1_cfg_ready", 32'(a_cfg_ready), 1);
    check("t1_act_ready", 32'(a_act_ready), 0);
    check("t1_loaded", 32'(a_wl), 0);
    check("t1_count", 32'(a_cnt), 0);
    check("t1_score_valid", 32'(a_sv), 0);
    act_valid = 1'b1;
    repeat (3) tick();
    act_valid = 1'b0;
    check("t1_no_fire", 32'(n_en), 0);

    // T2 load
    wq.delete();
    send(16'h0002);
    send(16'h0003);
    check("t2_loaded_early", 32'(a_wl), 0);
    send(16'h0004);
    cfg_valid = 1'b0;
    check("t2_nwen", 32'(n_wen), 3);
    check("t2_addrs", {wq[0][7:0], wq[1][7:0], wq[2][7:0]}, 32'h00000102);
    check("t2_loaded", 32'(a_wl), 1);

    // T3 infer with backpressure
    en_before = n_en;
    fire(1, 2, 3);
    check("t3_one_fire", 32'(n_en - en_before), 1);
    check("t3_score_valid", 32'(a_sv), 1);
    check("t3_score", 32'(n_score), 32'h14);
    repeat (5) tick();
    check("t3_hold_valid", 32'(a_sv), 1);
    check("t3_hold_act_ready", 32'(a_act_ready), 0);
    take();
    check("t3_count", 32'(a_cnt), 1);

    // T4 collision: activation wins, reload waits for OUT exit
    relu[0] = 16'd1; relu[1] = 16'd1; relu[2] = 16'd1;
    act_valid = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'h0005;
    @(negedge clk);
    check("t4_cfg_stalled", 32'(a_cfg_ready), 0);
    check("t4_fired", 32'(a_en), 1);
    tick();
    act_valid = 1'b0;
    wen_before = n_wen;
    repeat (2) tick();
    check("t4_no_write_in_out", 32'(n_wen - wen_before), 0);
    check("t4_score", 32'(n_score), 32'h9);
    take();
    send(16'h0005);
    check("t4_loaded_w1", 32'(a_wl), 0);
    send(16'h0006);
    check("t4_loaded_w2", 32'(a_wl), 0);
    send(16'h0007);
    cfg_valid = 1'b0;
    check("t4_loaded_w3", 32'(a_wl), 1);
    check("t4_count", 32'(a_cnt), 2);

    // T5 reset mid-load
    send(16'h0009);
    send(16'h0009);
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_loaded", 32'(a_wl), 0);
    check("t5_count", {16'(b_cnt), a_cnt}, 0);
    check("t5_cfg_ready", 32'(a_cfg_ready), 1);
    wq.delete();
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    cfg_valid = 1'b0;
    check("t5_addrs", {wq[0][7:0], wq[1][7:0], wq[2][7:0]}, 32'h00000102);
    check("t5_loaded_after", 32'(a_wl), 1);

    // T6 counter wrap with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      fire(i + 1, i + 2, 2);
      repeat (i % 3) tick();
      take();
      tick();
    end
    check("t6_count16", 32'(a_cnt), 5);
    check("t6_count2", 32'(b_cnt), 1);
    check("t6_scores_balanced", 32'(n_taken), 32'(n_fired));
    check("t6_queue_empty", 32'(exp_q.size()), 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
